datapath_stream_player: RTL and testbench

//  Read-side sequencer that sits directly downstream of the datapath FIFO: it drives the FIFO rd request,

---
 rtl/datapath_pkg.sv | 23 ++
 rtl/datapath_underrun_watchdog.sv | 42 ++++
 rtl/datapath_stream_player.sv | 129 ++++++++++++
 tb/tb_datapath_stream_player.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared types and constants for the datapath FIFO read-side player.
// Holds the player state encoding, default frame geometry and counter widths.
package datapath_pkg;

  localparam int DP_CH_WIDTH    = 32;
  localparam int DP_NUM_CH      = 6;
  localparam int DP_DATA_WIDTH  = DP_CH_WIDTH * DP_NUM_CH;
  localparam int UNDERRUN_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    PLAY  = 3'd2,
    STOP  = 3'd3,
    FAULT = 3'd4
  } player_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc(input logic [UNDERRUN_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/datapath_underrun_watchdog.sv
// Strobe watchdog: flags an underrun when TICK_PERIOD+2 cycles pass without a kick,
// and flags limit_hit on the underrun that completes UNDERRUN_LIMIT consecutive misses.
module datapath_underrun_watchdog #(
  parameter int TICK_PERIOD    = 30,
  parameter int UNDERRUN_LIMIT = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic run,
  input  logic kick,
  output logic underrun,
  output logic limit_hit
);

  localparam int TIMEOUT = TICK_PERIOD + 2;
  localparam int TIMER_W = $clog2(TIMEOUT);
  localparam int MISS_W  = $clog2(UNDERRUN_LIMIT + 1);

  logic [TIMER_W-1:0] timer_q;
  logic [MISS_W-1:0]  miss_q;

  // A kick in the expiry cycle wins, so no underrun is reported alongside a strobe.
  assign underrun  = run && !kick && (timer_q == TIMER_W'(TIMEOUT - 1));
  assign limit_hit = underrun && (miss_q == MISS_W'(UNDERRUN_LIMIT - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      timer_q <= '0;
      miss_q  <= '0;
    end else if (!run || kick) begin
      timer_q <= '0;
      miss_q  <= '0;
    end else if (underrun) begin
      timer_q <= '0;
      miss_q  <= miss_q + 1'b1;
    end else begin
      timer_q <= timer_q + 1'b1;
    end
  end

endmodule

// File: rtl/datapath_stream_player.sv
// Read-side sequencer for the datapath FIFO: primes, plays frames as channel words, detects underruns.
// Build option: define DATAPATH_PLAYER_ZERO_FILL_EN to emit a silent frame on every underrun.
module datapath_stream_player
  import datapath_pkg::*;
#(
  parameter int DATA_WIDTH     = DP_DATA_WIDTH,
  parameter int CH_WIDTH       = DP_CH_WIDTH,
  parameter int NUM_CH         = DP_NUM_CH,
  parameter int COUNT_WIDTH    = 11,
  parameter int START_LEVEL    = 512,
  parameter int TICK_PERIOD    = 30,
  parameter int UNDERRUN_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      enable,
  input  logic                      abort,
  input  logic                      clear_err,
  input  logic [COUNT_WIDTH-1:0]    fifo_data_count,
  input  logic                      fifo_rd_strobe,
  input  logic [DATA_WIDTH-1:0]     fifo_data,
  output logic                      fifo_rd,
  output logic [DATA_WIDTH-1:0]     ch_data,
  output logic                      ch_valid,
  output player_state_e             state,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt,
  output logic                      underrun_err,
  output logic [31:0]               frames_played
);

  if (DATA_WIDTH != NUM_CH * CH_WIDTH) begin : g_bad_width
    $error("datapath_stream_player: DATA_WIDTH must equal NUM_CH*CH_WIDTH");
  end

  player_state_e             state_q, state_d;
  logic                      stop_wait_q;
  logic                      wd_run, capture, underrun, limit_hit;
  logic [DATA_WIDTH-1:0]     ch_data_q;
  logic                      ch_valid_q;
  logic [UNDERRUN_CNT_W-1:0] underrun_cnt_q;
  logic                      underrun_err_q;
  logic [31:0]               frames_q;

  // abort cancels everything in its own cycle: no capture, no watchdog activity.
  assign wd_run  = (state_q == PLAY) && !abort;
  assign capture = fifo_rd_strobe && !abort && ((state_q == PLAY) || (state_q == STOP));

  datapath_underrun_watchdog #(
    .TICK_PERIOD    (TICK_PERIOD),
    .UNDERRUN_LIMIT (UNDERRUN_LIMIT)
  ) u_watchdog (
    .clk       (clk),
    .rstn      (rstn),
    .run       (wd_run),
    .kick      (capture),
    .underrun  (underrun),
    .limit_hit (limit_hit)
  );

  // NOTE: next-state is defaulted to the current state before the case, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (enable) state_d = PRIME;
        PRIME: begin
          if (!enable)                                           state_d = IDLE;
          else if (fifo_data_count >= COUNT_WIDTH'(START_LEVEL)) state_d = PLAY;
        end
        PLAY: begin
          if (limit_hit)    state_d = FAULT;
          else if (!enable) state_d = STOP;
        end
        // Two STOP cycles let a read tick already committed by the FIFO land.
        STOP:    if (stop_wait_q) state_d = IDLE;
        FAULT:   if (clear_err)   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      stop_wait_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_wait_q <= (state_q == STOP) && (state_d == STOP);
    end
  end

  // NOTE: the capture register is reset like any other flop; outputs must read 0 out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ch_data_q      <= '0;
      ch_valid_q     <= 1'b0;
      frames_q       <= '0;
      underrun_cnt_q <= '0;
      underrun_err_q <= 1'b0;
    end else begin
      ch_valid_q <= 1'b0;
      if (capture) begin
        ch_data_q  <= fifo_data;
        ch_valid_q <= 1'b1;
        frames_q   <= frames_q + 32'd1;
      end
`ifdef DATAPATH_PLAYER_ZERO_FILL_EN
      else if (underrun) begin
        ch_data_q  <= '0;
        ch_valid_q <= 1'b1;
      end
`endif
      if (underrun) underrun_cnt_q <= sat_inc(underrun_cnt_q);
      if ((state_q == PLAY) && (state_d == FAULT)) underrun_err_q <= 1'b1;
      else if (clear_err)                          underrun_err_q <= 1'b0;
    end
  end

  assign fifo_rd       = (state_q == PLAY);
  assign state         = state_q;
  assign ch_data       = ch_data_q;
  assign ch_valid      = ch_valid_q;
  assign underrun_cnt  = underrun_cnt_q;
  assign underrun_err  = underrun_err_q;
  assign frames_played = frames_q;

endmodule

// File: tb/tb_datapath_stream_player.sv
// Self-checking bench for datapath_stream_player: vector table for priming, scripted
// sequences for playback, underrun, fault, stop, abort and async reset; frames scoreboarded.
module tb_datapath_stream_player;
  import datapath_pkg::*;

  logic          clk = 1'b0;
  logic          rstn;
  logic          enable, abort, clear_err;
  logic [10:0]   fifo_data_count;
  logic          fifo_rd_strobe;
  logic [191:0]  fifo_data;
  logic          fifo_rd;
  logic [191:0]  ch_data;
  logic          ch_valid;
  player_state_e state;
  logic [15:0]   underrun_cnt;
  logic          underrun_err;
  logic [31:0]   frames_played;

  int checks = 0;
  int errors = 0;
  logic [191:0] sb[$];
  logic [191:0] sb_exp;
  int exp_frames;

  typedef struct {
    logic          en;
    logic [10:0]   cnt;
    player_state_e st;
    logic          rd;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  datapath_stream_player dut (
    .clk             (clk),
    .rstn            (rstn),
    .enable          (enable),
    .abort           (abort),
    .clear_err       (clear_err),
    .fifo_data_count (fifo_data_count),
    .fifo_rd_strobe  (fifo_rd_strobe),
    .fifo_data       (fifo_data),
    .fifo_rd         (fifo_rd),
    .ch_data         (ch_data),
    .ch_valid        (ch_valid),
    .state           (state),
    .underrun_cnt    (underrun_cnt),
    .underrun_err    (underrun_err),
    .frames_played   (frames_played)
  );

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [191:0] frame(input int n);
    logic [191:0] f;
    f = '0;
    for (int k = 0; k < 6; k++) f[32*k +: 32] = 32'hA5A5_0000 | (n << 8) | k;
    return f;
  endfunction

  task automatic strobe(input logic [191:0] d, input bit expect_capture);
    fifo_rd_strobe = 1'b1;
    fifo_data      = d;
    if (expect_capture) begin
      sb.push_back(d);
      exp_frames++;
    end
    step();
    fifo_rd_strobe = 1'b0;
  endtask

  task automatic expect_underrun_step();
`ifdef DATAPATH_PLAYER_ZERO_FILL_EN
    sb.push_back('0);
`endif
    step();
  endtask

  // Scoreboard: every ch_valid pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (rstn === 1'b1 && ch_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ch_valid_unexpected: got ch_data %0h expected no frame", ch_data);
      end else begin
        sb_exp = sb.pop_front();
        check("ch_data_frame", ch_data, sb_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 11'd100, IDLE,  1'b0};
    vecs[1] = '{1'b1, 11'd100, PRIME, 1'b0};
    vecs[2] = '{1'b1, 11'd511, PRIME, 1'b0};
    vecs[3] = '{1'b0, 11'd511, IDLE,  1'b0};
    vecs[4] = '{1'b1, 11'd100, PRIME, 1'b0};
    vecs[5] = '{1'b1, 11'd512, PLAY,  1'b1};

    exp_frames      = 0;
    rstn            = 1'b0;
    enable          = 1'b0;
    abort           = 1'b0;
    clear_err       = 1'b0;
    fifo_data_count = '0;
    fifo_rd_strobe  = 1'b0;
    fifo_data       = '0;
    step(3);
    check("rst_state", state, IDLE);
    check("rst_fifo_rd", fifo_rd, 1'b0);
    check("rst_ch_data", ch_data, '0);
    check("rst_frames", frames_played, 32'd0);
    #2 rstn = 1'b1;
    step();

    // Priming: threshold, enable drop in PRIME, entry to PLAY.
    for (int i = 0; i < 6; i++) begin
      enable          = vecs[i].en;
      fifo_data_count = vecs[i].cnt;
      step();
      check($sformatf("vec%0d_state", i), state, vecs[i].st);
      check($sformatf("vec%0d_fifo_rd", i), fifo_rd, vecs[i].rd);
    end

    // Nominal playback at the FIFO tick rate.
    for (int i = 1; i <= 3; i++) begin
      step(29);
      strobe(frame(i), 1'b1);
      check($sformatf("play_frames_%0d", i), frames_played, 32'(exp_frames));
      check("play_fifo_rd", fifo_rd, 1'b1);
    end

    // One missed frame: underrun lands exactly TICK_PERIOD+2 cycles after the last strobe.
    step(31);
    check("underrun_not_early", underrun_cnt, 16'd0);
    expect_underrun_step();
    check("underrun_cnt_1", underrun_cnt, 16'd1);
    check("underrun_state", state, PLAY);
    step();
`ifdef DATAPATH_PLAYER_ZERO_FILL_EN
    check("underrun_ch_data", ch_data, '0);
`else
    check("underrun_ch_data", ch_data, frame(3));
`endif

    // Sustained starvation: fourth consecutive miss forces FAULT.
    step(30);
    expect_underrun_step();
    check("underrun_cnt_2", underrun_cnt, 16'd2);
    step(31);
    expect_underrun_step();
    check("underrun_cnt_3", underrun_cnt, 16'd3);
    check("pre_fault_state", state, PLAY);
    step(31);
    expect_underrun_step();
    check("fault_state", state, FAULT);
    check("fault_err", underrun_err, 1'b1);
    check("fault_fifo_rd", fifo_rd, 1'b0);
    check("fault_cnt", underrun_cnt, 16'd4);

    enable = 1'b0;
    step();
    check("fault_en0", state, FAULT);
    enable = 1'b1;
    step();
    check("fault_en1", state, FAULT);
    strobe(frame(7), 1'b0);
    check("fault_strobe_ignored", frames_played, 32'(exp_frames));
    enable    = 1'b0;
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("clear_state", state, IDLE);
    check("clear_err", underrun_err, 1'b0);
    check("clear_cnt_held", underrun_cnt, 16'd4);

    // Graceful stop with a strobe already in flight.
    fifo_data_count = 11'd600;
    enable = 1'b1;
    step(2);
    check("stop_play", state, PLAY);
    enable = 1'b0;
    step();
    check("stop_state", state, STOP);
    check("stop_fifo_rd", fifo_rd, 1'b0);
    strobe(frame(4), 1'b1);
    check("stop_frames", frames_played, 32'(exp_frames));
    check("stop_hold", state, STOP);
    step();
    check("stop_idle", state, IDLE);

    // abort coincident with a strobe drops the frame.
    enable = 1'b1;
    step(2);
    check("abort_play", state, PLAY);
    abort = 1'b1;
    strobe(frame(5), 1'b0);
    abort = 1'b0;
    check("abort_state", state, IDLE);
    check("abort_fifo_rd", fifo_rd, 1'b0);
    check("abort_frames", frames_played, 32'(exp_frames));
    enable = 1'b0;
    step(2);
    strobe(frame(6), 1'b0);
    check("idle_strobe_ignored", frames_played, 32'(exp_frames));

    // Asynchronous reset in the middle of PLAY.
    enable = 1'b1;
    step(2);
    strobe(frame(9), 1'b1);
    step(2);
    check("mid_play", state, PLAY);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_state", state, IDLE);
    check("async_rst_fifo_rd", fifo_rd, 1'b0);
    check("async_rst_ch_data", ch_data, '0);
    check("async_rst_frames", frames_played, 32'd0);
    check("async_rst_cnt", underrun_cnt, 16'd0);
    check("async_rst_valid", ch_valid, 1'b0);
    enable = 1'b0;
    step(3);
    #2 rstn = 1'b1;
    step();
    check("post_rst_state", state, IDLE);
    check("sb_drained", 192'(sb.size()), 192'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
